// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage to divider request/result bundle
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit radix-2 restoring divider, optional DIV_ZERO_FAST_EN zero-divisor shortcut
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
`ifdef DIV_ZERO_FAST_EN
        ZERO = 2'd1,
`endif
        ON   = 2'd2,
        END  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    // {partial_rem[64:32], dividend_shift[31:0]}
    logic [64:0] work, work_nxt;
    logic [31:0] dvsr, dvsr_nxt;
    logic        q_neg, q_neg_nxt;
    logic        r_neg, r_neg_nxt;
    logic [63:0] result_nxt;
    logic        ready_nxt;

    logic [33:0] trial;
    logic [31:0] op1_mag, op2_mag;
    logic [31:0] quot_fin, rem_fin;
    logic        abort;

    // Next-state and datapath update for the FREE/ZERO/ON/END sequence
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        work_nxt   = work;
        dvsr_nxt   = dvsr;
        q_neg_nxt  = q_neg;
        r_neg_nxt  = r_neg;
        result_nxt = 64'h0;
        ready_nxt  = 1'b0;

        // Magnitudes of the operands; 0x80000000 maps onto itself, which is
        // exactly the unsigned magnitude we need.
        op1_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? 32'd0 - bus.opdata1_i : bus.opdata1_i;
        op2_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? 32'd0 - bus.opdata2_i : bus.opdata2_i;

        // Shifted partial remainder is work[63:31]; work[64] rides along as a
        // guard bit so the borrow lands cleanly in trial[33].
        trial    = work[64:31] - {2'b00, dvsr};
        quot_fin = q_neg ? 32'd0 - work[31:0]  : work[31:0];
        rem_fin  = r_neg ? 32'd0 - work[63:32] : work[63:32];
        abort    = bus.annul_i || !bus.start_i;

        case (state)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    dvsr_nxt  = op2_mag;
                    work_nxt  = {33'h0, op1_mag};
                    q_neg_nxt = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                    r_neg_nxt = bus.signed_div_i && bus.opdata1_i[31];
                    cnt_nxt   = 6'd0;
                    state_nxt = ON;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.opdata2_i == 32'h0) begin
                        state_nxt = ZERO;
                    end
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
                if (abort) begin
                    state_nxt = FREE;
                end else begin
                    state_nxt = END;
                    ready_nxt = 1'b1;
                end
            end
`endif
            ON: begin
                if (abort) begin
                    state_nxt = FREE;
                end else if (cnt != 6'd32) begin
                    if (!trial[33]) begin
                        work_nxt = {trial[32:0], work[30:0], 1'b1};
                    end else begin
                        work_nxt = {work[63:0], 1'b0};
                    end
                    cnt_nxt = cnt + 6'd1;
                end else begin
                    state_nxt  = END;
                    ready_nxt  = 1'b1;
                    result_nxt = {rem_fin, quot_fin};
`ifndef DIV_ZERO_FAST_EN
                    if (dvsr == 32'h0) begin
                        result_nxt = 64'h0;
                    end
`endif
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_nxt = FREE;
                end else begin
                    ready_nxt  = 1'b1;
                    result_nxt = bus.result_o;
                end
            end
            default: begin
                state_nxt = FREE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered result/ready outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= 6'd0;
            work         <= 65'h0;
            dvsr         <= 32'h0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            bus.result_o <= 64'h0;
            bus.ready_o  <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            work         <= work_nxt;
            dvsr         <= dvsr_nxt;
            q_neg        <= q_neg_nxt;
            r_neg        <= r_neg_nxt;
            bus.result_o <= result_nxt;
            bus.ready_o  <= ready_nxt;
        end
    end

endmodule
